// File: rtl/stopwatch_pkg.sv
// Shared display constants for the stopwatch: active-low segment patterns,
// "all off" values and the digit scanner state type.
package stopwatch_pkg;

    // Anode / cathode idle values (all active-low, so all ones is dark).
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Decode table, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    // Non-BCD nibbles (10-15) show a dash on segment g only.
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Scanner FSM: SHOW drives the selected digit, BLANK holds anodes off.
    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Table lookup; every non-decimal code maps to a dash.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner. Advances one digit per rising edge
// of the segment-rate level, inserts an anode-off gap after each advance,
// latches a fresh BCD snapshot at every frame wrap and applies blink/dp masks.
module seven_seg_scanner
    import stopwatch_pkg::*;
#(
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seg_lvl,
    input  logic        blink_lvl,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    // Reload value for the gap counter; unused when the gap is disabled.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d, idx_inc;
    logic [15:0]      snap_q, snap_d;
    logic             seg_prev_q, seg_prev_d;
    logic             blink_q, blink_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             seg_rise;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;

    // seg_prev resets high so a level already high at reset release is not an edge.
    assign seg_rise = seg_lvl & ~seg_prev_q;
    assign cur_nib  = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd   (cur_nib),
        .seg_n (dec_seg)
    );

    // Scan sequencing: digit advance, frame snapshot and anode-off gap timing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        idx_inc    = idx_q + 2'd1;
        seg_prev_d = seg_lvl;
        blink_d    = blink_lvl;
        if (!enable) begin
            state_d = SHOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SHOW: begin
                    if (seg_rise) begin
                        idx_d = idx_inc;
                        // Snapshot only on wrap so a frame never mixes old and new digits.
                        if (idx_inc == 2'd0) begin
                            snap_d = digits;
                        end
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                BLANK: begin
                    // Edges arriving here (including on the exit cycle) are dropped.
                    if (cnt_q == '0) begin
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = SHOW;
            endcase
        end
    end

    // Output pattern for the current state/index, registered one cycle later.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (enable && (state_q == SHOW) && !(blink_mask[idx_q] && blink_q)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg;
            dp_d  = ~dp_mask[idx_q];
        end
    end

    // State and output registers with asynchronous reset to a dark display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SHOW;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            snap_q     <= 16'h0000;
            seg_prev_q <= 1'b1;
            blink_q    <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            seg_prev_q <= seg_prev_d;
            blink_q    <= blink_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: one instance with a 4-cycle gap and one with
// the gap disabled. Stimulus pushes cycle-tagged expectations into a queue;
// a monitor on the falling edge pops and compares them against the outputs.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        seg_lvl, seg_lvl_z;
    logic        blink_lvl;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;

    logic [3:0]  an_m, an_z;
    logic [6:0]  seg_m, seg_z;
    logic        dp_m, dp_z;
    logic [1:0]  idx_m, idx_z;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         tag;
        bit         z;
        bit         chk_disp;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seven_seg_scanner #(.BLANK_CYCLES(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_lvl    (seg_lvl),
        .blink_lvl  (blink_lvl),
        .enable     (enable),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an_m),
        .seg        (seg_m),
        .dp         (dp_m),
        .digit_idx  (idx_m)
    );

    seven_seg_scanner #(.BLANK_CYCLES(0), .CNT_W(16)) dut_z (
        .clk        (clk),
        .reset      (reset),
        .seg_lvl    (seg_lvl_z),
        .blink_lvl  (blink_lvl),
        .enable     (enable),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an_z),
        .seg        (seg_z),
        .dp         (dp_z),
        .digit_idx  (idx_z)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle tag has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t       e;
            logic [3:0] a;
            logic [6:0] s;
            logic       d;
            logic [1:0] i;
            bit         ok;
            e = sb.pop_front();
            a = e.z ? an_z  : an_m;
            s = e.z ? seg_z : seg_m;
            d = e.z ? dp_z  : dp_m;
            i = e.z ? idx_z : idx_m;
            checks++;
            ok = (i == e.idx) && (e.tag == cyc);
            if (e.chk_disp && !(a == e.an && s == e.seg && d == e.dp)) ok = 0;
            if (!ok) begin
                failures++;
                $display("FAIL %s%s cyc=%0d tag=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                         e.name, e.z ? "_z" : "", cyc, e.tag, a, s, d, i,
                         e.an, e.seg, e.dp, e.idx);
            end
        end
    end

    task automatic sb_push(input int tag, input bit z, input bit chk_disp,
                           input logic [3:0] an, input logic [6:0] sg,
                           input logic d, input logic [1:0] idx, input string name);
        exp_t e;
        e.tag = tag; e.z = z; e.chk_disp = chk_disp;
        e.an = an; e.seg = sg; e.dp = d; e.idx = idx; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One digit advance. mode 0: single edge; mode 1: extra edge inside the
    // gap; mode 2: extra edge coinciding with the gap exit. Extra edges go to
    // the gapped instance only and must be dropped.
    task automatic advance(input int mode, input logic [1:0] idx, input logic [3:0] an,
                           input logic [6:0] sg, input logic d, input string name);
        int p;
        p = cyc;
        sb_push(p + 2, 1'b1, 1'b1, an, sg, d, idx, name);
        sb_push(p + 3, 1'b0, 1'b1, 4'b1111, 7'h7F, 1'b1, idx, {name, "_gap"});
        sb_push(p + 6, 1'b0, 1'b1, an, sg, d, idx, name);
        if (mode != 0) sb_push(p + 9, 1'b0, 1'b1, an, sg, d, idx, {name, "_drop"});
        seg_lvl = 1'b1; seg_lvl_z = 1'b1;
        tick(1);
        seg_lvl = 1'b0; seg_lvl_z = 1'b0;
        if (mode == 1) begin
            tick(1); seg_lvl = 1'b1;
            tick(1); seg_lvl = 1'b0;
        end else if (mode == 2) begin
            tick(3); seg_lvl = 1'b1;
            tick(1); seg_lvl = 1'b0;
        end
        tick(p + 12 - cyc);
    endtask

    initial begin
        int r;
        reset      = 1'b1;
        seg_lvl    = 1'b1;
        seg_lvl_z  = 1'b1;
        blink_lvl  = 1'b0;
        enable     = 1'b1;
        digits     = 16'h1259;
        blink_mask = 4'b0000;
        dp_mask    = 4'b0100;
        tick(3);

        // Reset values, then release with seg_lvl high: no advance.
        sb_push(cyc, 1'b0, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "reset_vals");
        sb_push(cyc, 1'b1, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "reset_vals");
        r = cyc;
        reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            sb_push(r + i, 1'b0, 1'b0, 4'b1111, 7'h7F, 1'b1, 2'd0, "no_spurious_edge");
            if (i == 50) sb_push(r + i, 1'b1, 1'b0, 4'b1111, 7'h7F, 1'b1, 2'd0, "no_spurious_edge");
        end
        tick(101);

        // Disable darkens the display; re-enable shows digit 0 of the zero snapshot.
        enable = 1'b0;
        sb_push(cyc + 2, 1'b0, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "enable_off");
        sb_push(cyc + 2, 1'b1, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "enable_off");
        tick(3);
        seg_lvl = 1'b0; seg_lvl_z = 1'b0;
        enable = 1'b1;
        sb_push(cyc + 1, 1'b0, 1'b1, 4'b1110, 7'b1000000, 1'b1, 2'd0, "enable_on");
        sb_push(cyc + 1, 1'b1, 1'b1, 4'b1110, 7'b1000000, 1'b1, 2'd0, "enable_on");
        tick(3);

        // Walk out the zero snapshot, wrap into 16'h1259.
        advance(0, 2'd1, 4'b1101, 7'b1000000, 1'b1, "zero_idx1");
        advance(0, 2'd2, 4'b1011, 7'b1000000, 1'b0, "zero_idx2_dp");
        advance(0, 2'd3, 4'b0111, 7'b1000000, 1'b1, "zero_idx3");
        advance(0, 2'd0, 4'b1110, 7'b0010000, 1'b1, "wrap_9");
        advance(1, 2'd1, 4'b1101, 7'b0010010, 1'b1, "show_5_edge_in_gap");
        advance(0, 2'd2, 4'b1011, 7'b0100100, 1'b0, "show_2");

        // Digits change mid-frame: old leftmost digit still shows.
        digits = 16'h3000;
        advance(0, 2'd3, 4'b0111, 7'b1111001, 1'b1, "old_1_held");
        advance(0, 2'd0, 4'b1110, 7'b1000000, 1'b1, "new_0");
        advance(2, 2'd1, 4'b1101, 7'b1000000, 1'b1, "new_0_edge_at_exit");
        advance(0, 2'd2, 4'b1011, 7'b1000000, 1'b0, "new_0_dp");
        advance(0, 2'd3, 4'b0111, 7'b0110000, 1'b1, "new_3");

        // Non-decimal nibbles decode to a dash; dp on digit 2 only.
        digits = 16'h7AF8;
        advance(0, 2'd0, 4'b1110, 7'b0000000, 1'b1, "show_8");
        advance(0, 2'd1, 4'b1101, 7'b0111111, 1'b1, "dash_F");
        advance(0, 2'd2, 4'b1011, 7'b0111111, 1'b0, "dash_A_dp");
        advance(0, 2'd3, 4'b0111, 7'b1111000, 1'b1, "show_7");

        // Blink digits 1:0 while blink_lvl is high.
        blink_mask = 4'b0011;
        blink_lvl  = 1'b1;
        tick(2);
        advance(0, 2'd0, 4'b1111, 7'h7F, 1'b1, "blink_idx0");
        advance(0, 2'd1, 4'b1111, 7'h7F, 1'b1, "blink_idx1");
        advance(0, 2'd2, 4'b1011, 7'b0111111, 1'b0, "blink_idx2_unaff");
        blink_lvl = 1'b0;
        advance(0, 2'd3, 4'b0111, 7'b1111000, 1'b1, "blink_low_idx3");
        advance(0, 2'd0, 4'b1110, 7'b0000000, 1'b1, "blink_low_idx0");

        // In-place blink toggle on digit 0: two-cycle latency each way.
        blink_lvl = 1'b1;
        sb_push(cyc + 2, 1'b0, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "blink_on");
        sb_push(cyc + 2, 1'b1, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "blink_on");
        tick(4);
        blink_lvl = 1'b0;
        sb_push(cyc + 2, 1'b0, 1'b1, 4'b1110, 7'b0000000, 1'b1, 2'd0, "blink_off");
        sb_push(cyc + 2, 1'b1, 1'b1, 4'b1110, 7'b0000000, 1'b1, 2'd0, "blink_off");
        tick(4);

        // Reset asserted inside the gap takes effect immediately.
        seg_lvl = 1'b1; seg_lvl_z = 1'b1;
        tick(1);
        seg_lvl = 1'b0; seg_lvl_z = 1'b0;
        tick(1);
        reset = 1'b1;
        sb_push(cyc, 1'b0, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "reset_in_gap");
        sb_push(cyc, 1'b1, 1'b1, 4'b1111, 7'h7F, 1'b1, 2'd0, "reset_in_gap");
        tick(2);
        reset = 1'b0;
        sb_push(cyc + 1, 1'b0, 1'b1, 4'b1110, 7'b1000000, 1'b1, 2'd0, "after_reset");
        sb_push(cyc + 1, 1'b1, 1'b1, 4'b1110, 7'b1000000, 1'b1, 2'd0, "after_reset");
        tick(4);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
            failures += sb.size();
            checks   += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumer end of the clock-divider outputs: takes the segment-rate and blink-rate square waves as levels on clk, edge-detects them, and time-multiplexes a 4-digit common-anode seven-segment display.
- Shows a 16-bit BCD snapshot (MM:SS) from the stopwatch counter, with per-digit blink blanking for adjust mode and a per-digit decimal point.
- Inserts a programmable anode-off gap at every digit switch to prevent ghosting.

Parameters:
- BLANK_CYCLES, 1000, number of clk cycles with all anodes off after each digit advance; 0 disables the gap.
- CNT_W, 16, width of the blank counter; must hold BLANK_CYCLES.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- seg_lvl  in  1  segment-rate square wave from the divider (~500 Hz to 1 kHz)
- blink_lvl  in  1  blink-rate square wave from the divider (~4 Hz)
- enable  in  1  display enable
- digits  in  16  four BCD nibbles; [3:0] is the rightmost digit, [15:12] the leftmost
- blink_mask  in  4  bit i=1 makes digit i blank while blink_lvl is high
- dp_mask  in  4  bit i=1 lights the decimal point of digit i
- an  out  4  anodes, active-low; an[0] is the rightmost digit
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- digit_idx  out  2  index of the digit currently selected

Behaviour:
- Reset values (async): an=4'b1111, seg=7'b1111111, dp=1, digit_idx=0, state=SHOW, blank counter=0, snapshot=16'h0000, seg_prev=1.
- Edge detect: seg_prev is registered from seg_lvl every cycle. seg_rise = seg_lvl & ~seg_prev. Because seg_prev resets to 1, no spurious edge occurs when reset releases with seg_lvl already high.
- blink_lvl is used as a level, registered once.
- FSM has two states, SHOW and BLANK.
- In SHOW, seg_rise with enable=1:
  - digit_idx <= digit_idx+1, wrapping 3->0.
  - If the new index is 0, snapshot <= digits, so each frame is coherent.
  - If BLANK_CYCLES>0: go to BLANK, counter <= BLANK_CYCLES-1.
- In BLANK: an=4'b1111. The counter decrements each cycle; at 0 the FSM returns to SHOW. A seg_rise during BLANK is dropped.
- When BLANK_CYCLES=0, the FSM never leaves SHOW. The new digit appears one cycle after the edge.
- Outputs in SHOW are all registered, with one cycle of latency from the state/index change:
  - an = ~(4'b0001 << digit_idx), forced to 4'b1111 if blink_mask[idx] & blink_lvl_q.
  - seg = decoded snapshot nibble[idx].
  - dp = ~dp_mask[idx].
  - The blinked digit also forces seg=7'h7F and dp=1.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibbles 10-15 = 0111111 (dash, g only)
- enable=0: an=4'b1111, seg=7'h7F, dp=1; digit_idx and snapshot held; seg_rise ignored; state forced to SHOW and counter cleared. Scanning resumes at the next seg_rise after enable returns to 1.
- Simultaneous seg_rise and the BLANK-count-0 exit: the exit wins and the edge is dropped.
- Reset mid-scan or mid-BLANK returns all state to the reset values immediately.
- digits changing mid-frame has no effect until the next 3->0 wrap.

Decomposition:
- Shared package `stopwatch_pkg`:
  - SEG_* localparams for the 16-entry decode table.
  - AN_OFF=4'b1111, SEG_OFF=7'h7F.
  - FSM state typedef {SHOW, BLANK}.
- One sub-module, `bcd_to_7seg`: combinational nibble -> active-low 7-bit pattern. It is reused by the top-level mode display.

Test Plan:
- Reset with seg_lvl=1 held, release -> no advance, digit_idx=0, an=1111, seg=7F, for 100 cycles.
- BLANK_CYCLES=4, digits=16'h1259, enable=1; seg_lvl rise at a wrap:
  - an=1111 for 4 cycles after the edge.
  - Then, for the digit at idx 0: an=1110, seg=0010000 (the 9).
  - Next edges show 5 (0010010, an=1101), 2 (0100100, an=1011), 1 (1111001, an=0111).
- Change digits to 16'h3000 while idx=2 -> digits 2 and 3 still show old values until the next idx 3->0 wrap; then the snapshot shows 3,0,0,0.
- blink_mask=4'b0011, blink_lvl toggles -> an[1:0] held 1 while blink_lvl=1; normal pattern while 0; an[3:2] unaffected.
- digits nibble=4'hA, dp_mask=4'b0100 -> at idx 2, seg=0111111 and dp=0; other digits dp=1.
- Second seg_rise inside the BLANK window -> ignored, idx advances by one only. Assert reset during BLANK -> next cycle an=1111, idx=0, state=SHOW.
